truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Sequential stimulus-and-capture engine for the team's 3-input combinational function blocks.
- Drives the function's inputs through every input combination, samples its single output, and records the results as a truth-table word.
- Compares the captured table against an expected table and reports pass/fail, the number of failing rows, and the first failing row.
- Sits on the opposite side of the function's A/B/C -> F interface, replacing hand-written exhaustive testbench sequences with a synthesizable self-checker.

Parameters:
- N_IN, 3, number of function inputs; table width is 2**N_IN.
- SETTLE, 1, extra cycles each vector is held before sampling; 0 is legal; each vector occupies SETTLE+1 cycles.
- EXPECTED, 8'h1D, expected table; bit i = F for input index i. The default encodes F = A'B + B'C' + A'BC.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  sweep request; sampled only in IDLE.
- stim  output  N_IN  drives the function inputs; stim[N_IN-1] = A, stim[0] = C for N_IN=3.
- f_in  input  1  function output under test.
- busy  output  1  high while a sweep is running.
- done  output  1  one-cycle pulse when results are valid.
- pass  output  1  captured table == EXPECTED; held until the next start.
- table_out  output  2**N_IN  captured truth table; held until the next start.
- fail_count  output  N_IN+1  number of rows differing from EXPECTED.
- first_fail  output  N_IN  lowest failing index; 0 when none.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE and all counters cleared. Every output is 0: stim, busy, done, pass, table_out, fail_count, first_fail.
- States: IDLE, RUN, DONE.
- IDLE:
  - stim=0, busy=0.
  - start=1 at an edge -> RUN. That same edge sets busy=1, idx=0, cnt=0, stim=0, and clears table_out, fail_count, first_fail and pass.
- RUN, each edge:
  - If cnt<SETTLE: cnt+1.
  - If cnt==SETTLE (sample edge):
    - table_out[idx]<=f_in; cnt<=0.
    - If f_in!=EXPECTED[idx]: fail_count+1. If this is the first failure, first_fail<=idx.
    - If idx<2**N_IN-1: idx+1 and stim<=idx+1 on the same edge.
    - Else: stim<=0, busy<=0, done<=1, and pass<=(final table incl. this bit == EXPECTED) -> DONE.
- DONE: lasts exactly one cycle (done=1), then done<=0 -> IDLE. start is ignored in this cycle.
- Latency: the start edge to the done-asserting edge is 2**N_IN*(SETTLE+1) cycles. Defaults give 16.
- start while in RUN or DONE is ignored. There is no queuing and no restart.
- Reset asserted mid-sweep aborts immediately to the reset values. A following start runs a full sweep from index 0.
- idx and cnt wrap never occurs. Terminal index 2**N_IN-1 always ends the sweep.
- Results (pass, table_out, fail_count, first_fail) persist in IDLE until the next accepted start.
- f_in is assumed synchronous/settled within SETTLE+1 cycles. No synchronizer.

Test Plan:
1. Correct function model (F=A'B+B'C'+A'BC) attached, defaults, start pulse at cycle 0 -> stim steps 0..7, two cycles each; done at cycle 16; table_out=8'h1D, pass=1, fail_count=0, first_fail=0.
2. f_in tied 0 -> table_out=8'h00, pass=0, fail_count=4, first_fail=0.
3. Model with row 3 inverted (F=0 at A,B,C=011) -> table_out=8'h15, pass=0, fail_count=1, first_fail=3.
4. start re-pulsed at cycles 5 and 16 (DONE cycle) -> both ignored; a single done at cycle 16. A start at cycle 18 begins a new sweep and clears results that cycle.
5. rst_n low at cycle 7 for 2 cycles -> all outputs 0 immediately, no done. Then start -> a full 16-cycle sweep with table_out=8'h1D, pass=1.
6. SETTLE=3 with a correct model -> each vector held 4 cycles; done at cycle 32, pass=1. SETTLE=0 -> done at cycle 8, pass=1.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//
// Exhaustive stimulus-and-capture engine for an N_IN-input combinational
// function. On start it steps stim through every input index 0..2**N_IN-1.
// Each vector is held for SETTLE+1 cycles, and f_in is sampled on the last
// cycle of that window. The captured bits form a truth-table word, which is
// compared against EXPECTED. The block reports pass/fail, the number of
// failing rows, and the lowest failing row.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   sweep request, sampled only while idle
//   stim       out  [N_IN-1:0] function inputs (stim[N_IN-1] = A ... stim[0] = C)
//   f_in       in   function output under test
//   busy       out  high while a sweep is running
//   done       out  one-cycle pulse when results become valid
//   pass       out  captured table equals EXPECTED; held until next start
//   table_out  out  [2**N_IN-1:0] captured table, bit i = F(i)
//   fail_count out  [N_IN:0] number of rows differing from EXPECTED
//   first_fail out  [N_IN-1:0] lowest failing row index, 0 when none
//   fsm_state  out  [1:0] current FSM state (0 idle, 1 run, 2 done)
//
// Handshake: start is a level sampled on a rising edge only in idle. A start
// seen while running or in the done cycle is dropped, not queued. done pulses
// for exactly one cycle. Results stay stable from that cycle until the next
// accepted start.
// -----------------------------------------------------------------------------
module truth_table_sweeper #(
  parameter int                    N_IN     = 3,
  parameter int                    SETTLE   = 1,
  parameter logic [(2**N_IN)-1:0]  EXPECTED = 8'h1D
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [N_IN-1:0]        stim,
  input  logic                   f_in,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(2**N_IN)-1:0]   table_out,
  output logic [N_IN:0]          fail_count,
  output logic [N_IN-1:0]        first_fail,
  output logic [1:0]             fsm_state
);

  localparam int TW = 2**N_IN;

  // The settle counter needs at least one bit, even when SETTLE is 0.
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  localparam logic [CW-1:0]   CNT_SETTLE = CW'(SETTLE);
  localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
  localparam logic [N_IN-1:0] IDX_ONE    = N_IN'(1);
  localparam logic [N_IN-1:0] IDX_LAST   = '1;
  localparam logic [N_IN:0]   FC_ONE     = (N_IN + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [N_IN-1:0] idx;
  logic [CW-1:0]   cnt;

  logic            accept;
  logic            sample;
  logic            last_row;
  logic            row_fail;
  logic [TW-1:0]   table_next;

  assign fsm_state = state;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic and per-cycle decode
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    sample     = 1'b0;
    last_row   = (idx == IDX_LAST);
    row_fail   = (f_in != EXPECTED[idx]);

    // The table as it will be after this edge's capture. pass must include
    // the final bit, so it is computed from this value and not from the
    // registered table.
    table_next      = table_out;
    table_next[idx] = f_in;

    case (state)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt == CNT_SETTLE) begin
          sample = 1'b1;
          if (last_row) begin
            next_state = S_DONE;
          end
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: vector sequencing, capture and scoring
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      cnt        <= '0;
      stim       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      table_out  <= '0;
      fail_count <= '0;
      first_fail <= '0;
    end else begin
      // done is a single-cycle pulse. It is only ever set on the final sample
      // edge, so the done cycle clears it again.
      done <= 1'b0;

      if (accept) begin
        busy       <= 1'b1;
        idx        <= '0;
        cnt        <= '0;
        stim       <= '0;
        pass       <= 1'b0;
        table_out  <= '0;
        fail_count <= '0;
        first_fail <= '0;
      end else if (state == S_RUN) begin
        if (!sample) begin
          cnt <= cnt + CNT_ONE;
        end else begin
          cnt       <= '0;
          table_out <= table_next;

          if (row_fail) begin
            fail_count <= fail_count + FC_ONE;
            // A zero count means no row has failed yet in this sweep.
            if (fail_count == '0) begin
              first_fail <= idx;
            end
          end

          if (!last_row) begin
            idx  <= idx + IDX_ONE;
            stim <= idx + IDX_ONE;
          end else begin
            stim <= '0;
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (table_next == EXPECTED);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
//
// Three sweepers share one clock and reset:
//   u0  SETTLE=1  f_in selected by f_mode (0 correct, 1 tied low, 2 row 3 bad)
//   u1  SETTLE=3  correct function
//   u2  SETTLE=0  correct function
// Each expected result word is {done_cycle[15:0], table[7:0], pass, fail_count[3:0],
// first_fail[2:0]}. It is queued when a sweep is launched and popped by a
// monitor when that DUT pulses done.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  int   f_mode  = 0;
  int   cyc     = 0;

  int checks = 0;
  int passes = 0;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q2[$];

  // DUT u0
  logic [2:0] stim0, ff0;
  logic       f0, busy0, done0, pass0;
  logic [7:0] tbl0;
  logic [3:0] fc0;
  logic [1:0] st0;
  // DUT u1
  logic [2:0] stim1, ff1;
  logic       f1, busy1, done1, pass1;
  logic [7:0] tbl1;
  logic [3:0] fc1;
  logic [1:0] st1;
  // DUT u2
  logic [2:0] stim2, ff2;
  logic       f2, busy2, done2, pass2;
  logic [7:0] tbl2;
  logic [3:0] fc2;
  logic [1:0] st2;

  // ---------------------------------------------------------------------------
  // Clock / cycle counter (cyc = number of rising edges seen so far)
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference function: F = A'B + B'C' + A'BC
  function automatic logic fmodel(input logic [2:0] s);
    logic a, b, c;
    a = s[2];
    b = s[1];
    c = s[0];
    return (~a & b) | (~b & ~c) | (~a & b & c);
  endfunction

  always_comb begin
    f0 = 1'b0;
    if (f_mode == 0)      f0 = fmodel(stim0);
    else if (f_mode == 2) f0 = fmodel(stim0) ^ (stim0 == 3'd3);
    f1 = fmodel(stim1);
    f2 = fmodel(stim2);
  end

  truth_table_sweeper #(.N_IN(3), .SETTLE(1), .EXPECTED(8'h1D)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stim(stim0), .f_in(f0),
    .busy(busy0), .done(done0), .pass(pass0), .table_out(tbl0),
    .fail_count(fc0), .first_fail(ff0), .fsm_state(st0)
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE(3), .EXPECTED(8'h1D)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stim(stim1), .f_in(f1),
    .busy(busy1), .done(done1), .pass(pass1), .table_out(tbl1),
    .fail_count(fc1), .first_fail(ff1), .fsm_state(st1)
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE(0), .EXPECTED(8'h1D)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stim(stim2), .f_in(f2),
    .busy(busy2), .done(done2), .pass(pass2), .table_out(tbl2),
    .fail_count(fc2), .first_fail(ff2), .fsm_state(st2)
  );

  // ---------------------------------------------------------------------------
  // Check helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: event not expected (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] pack(input int c, input logic [7:0] tt,
                                       input logic p, input logic [3:0] fc,
                                       input logic [2:0] ff);
    return {16'(c), tt, p, fc, ff};
  endfunction

  task automatic mon_check(input string tag, input logic [31:0] e, input logic [31:0] a);
    chk({tag, "_done_cycle"}, 32'(a[31:16]), 32'(e[31:16]));
    chk({tag, "_table"},      32'(a[15:8]),  32'(e[15:8]));
    chk({tag, "_pass"},       32'(a[7]),     32'(e[7]));
    chk({tag, "_fail_count"}, 32'(a[6:3]),   32'(e[6:3]));
    chk({tag, "_first_fail"}, 32'(a[2:0]),   32'(e[2:0]));
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitors: one per DUT, popping on every done pulse
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n && done0) begin
      if (exp_q0.size() == 0) fail_now("u0_spurious_done");
      else mon_check("u0", exp_q0.pop_front(), pack(cyc, tbl0, pass0, fc0, ff0));
    end
  end

  always @(negedge clk) begin
    if (rst_n && done1) begin
      if (exp_q1.size() == 0) fail_now("u1_spurious_done");
      else mon_check("u1", exp_q1.pop_front(), pack(cyc, tbl1, pass1, fc1, ff1));
    end
  end

  always @(negedge clk) begin
    if (rst_n && done2) begin
      if (exp_q2.size() == 0) fail_now("u2_spurious_done");
      else mon_check("u2", exp_q2.pop_front(), pack(cyc, tbl2, pass2, fc2, ff2));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: call at a falling edge. Raises start for one rising edge and
  // returns at the following falling edge with e = the accepting edge.
  // ---------------------------------------------------------------------------
  task automatic issue_start(input bit which, output int e);
    if (which) start_b = 1'b1;
    else       start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    e = cyc;
  endtask

  task automatic check_u0_zero(input string tag);
    chk({tag, "_stim"},       32'(stim0), 32'd0);
    chk({tag, "_busy"},       32'(busy0), 32'd0);
    chk({tag, "_done"},       32'(done0), 32'd0);
    chk({tag, "_pass"},       32'(pass0), 32'd0);
    chk({tag, "_table"},      32'(tbl0),  32'd0);
    chk({tag, "_fail_count"}, 32'(fc0),   32'd0);
    chk({tag, "_first_fail"}, 32'(ff0),   32'd0);
    chk({tag, "_state"},      32'(st0),   32'd0);
  endtask

  task automatic report();
    $display("%0d/%0d checks passed", passes, checks);
  endtask

  // Watchdog: a missing done or a stall still ends with a summary.
  initial begin
    #100000;
    fail_now("watchdog_timeout");
    report();
    $finish;
  end

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    int e, e2;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_u0_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: correct function, stim stepping, done latency, persistence.
    f_mode = 0;
    issue_start(1'b0, e);
    exp_q0.push_back(pack(e + 16, 8'h1D, 1'b1, 4'd0, 3'd0));
    chk("t1_busy_start", 32'(busy0), 32'd1);
    chk("t1_stim_start", 32'(stim0), 32'd0);
    for (int t = 1; t < 16; t++) begin
      @(negedge clk);
      chk("t1_stim", 32'(stim0), 32'(t / 2));
      chk("t1_busy", 32'(busy0), 32'd1);
    end
    @(negedge clk);
    chk("t1_busy_end", 32'(busy0), 32'd0);
    chk("t1_stim_end", 32'(stim0), 32'd0);
    chk("t1_done_high", 32'(done0), 32'd1);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done0), 32'd0);
    repeat (3) @(negedge clk);
    chk("t1_hold_table", 32'(tbl0),  32'h1D);
    chk("t1_hold_pass",  32'(pass0), 32'd1);
    chk("t1_idle_state", 32'(st0),   32'd0);

    // Test 2: f_in tied low.
    f_mode = 1;
    issue_start(1'b0, e);
    exp_q0.push_back(pack(e + 16, 8'h00, 1'b0, 4'd4, 3'd0));
    repeat (17) @(negedge clk);

    // Test 3: row 3 inverted.
    f_mode = 2;
    issue_start(1'b0, e);
    exp_q0.push_back(pack(e + 16, 8'h15, 1'b0, 4'd1, 3'd3));
    repeat (17) @(negedge clk);

    // Test 4: start during RUN (edge e+5) and DONE (edge e+17) is ignored.
    // A start at edge e+18 launches a new sweep.
    f_mode = 2;
    issue_start(1'b0, e);
    exp_q0.push_back(pack(e + 16, 8'h15, 1'b0, 4'd1, 3'd3));
    repeat (4) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("t4_busy_after_restart", 32'(busy0), 32'd1);
    repeat (11) @(negedge clk);
    start_a = 1'b1;
    f_mode  = 0;
    @(negedge clk);
    @(negedge clk);
    start_a = 1'b0;
    e2 = e + 18;
    exp_q0.push_back(pack(e2 + 16, 8'h1D, 1'b1, 4'd0, 3'd0));
    chk("t4_new_busy",        32'(busy0), 32'd1);
    chk("t4_cleared_table",   32'(tbl0),  32'd0);
    chk("t4_cleared_fc",      32'(fc0),   32'd0);
    chk("t4_cleared_ff",      32'(ff0),   32'd0);
    repeat (17) @(negedge clk);

    // Test 5: reset mid-sweep aborts. A new start then runs a full sweep.
    f_mode = 2;
    issue_start(1'b0, e);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_u0_zero("t5_abort");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_no_done_table", 32'(tbl0), 32'd0);
    f_mode = 0;
    issue_start(1'b0, e);
    exp_q0.push_back(pack(e + 16, 8'h1D, 1'b1, 4'd0, 3'd0));
    repeat (17) @(negedge clk);

    // Test 6: SETTLE=3 (done after 32 edges) and SETTLE=0 (after 8 edges).
    issue_start(1'b1, e);
    exp_q1.push_back(pack(e + 32, 8'h1D, 1'b1, 4'd0, 3'd0));
    exp_q2.push_back(pack(e + 8,  8'h1D, 1'b1, 4'd0, 3'd0));
    chk("t6_u1_busy", 32'(busy1), 32'd1);
    chk("t6_u2_busy", 32'(busy2), 32'd1);
    repeat (8) @(negedge clk);
    chk("t6_u2_stim_end", 32'(stim2), 32'd0);
    chk("t6_u1_stim_mid", 32'(stim1), 32'd2);
    repeat (26) @(negedge clk);

    // Every launched sweep must have produced exactly one done.
    chk("q0_drained", 32'(exp_q0.size()), 32'd0);
    chk("q1_drained", 32'(exp_q1.size()), 32'd0);
    chk("q2_drained", 32'(exp_q2.size()), 32'd0);

    report();
    $finish;
  end

endmodule
